// File: rtl/int_ctrl_if.sv
// CPU-side bus of the interrupt controller: request/acknowledge handshake plus
// the word-addressed register port for MASK/PEND/CAUSE/EOI.
interface int_ctrl_if;
  // Handshake: intr is held high only while a request is open. The CPU takes it
  // by pulsing inta for one cycle, which transfers int_id/cause. No new request
  // is raised until the CPU pulses eoi or writes address 3.
  logic        ie;
  logic        inta;
  logic        eoi;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        intr;
  logic [2:0]  int_id;
  logic [31:0] cause;

  modport slave (
    input  ie, inta, eoi, we, addr, wdata,
    output rdata, intr, int_id, cause
  );

  modport master (
    output ie, inta, eoi, we, addr, wdata,
    input  rdata, intr, int_id, cause
  );
endinterface

// File: rtl/int_ctrl.sv
// Eight-input vectored interrupt controller: synchronised edge capture, masked
// lowest-index priority, single outstanding request held until EOI.
module int_ctrl (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic [7:0]        irq,
  int_ctrl_if.slave         bus,
  output logic [1:0]        dbg_state
);
  localparam int N_IRQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_IRQ-1:0]   s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [N_IRQ-1:0]   pend_q, pend_d;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic               intr_q, intr_d;
  logic [2:0]         int_id_q, int_id_d;

  logic [N_IRQ-1:0]   edge_det;
  logic [N_IRQ-1:0]   pm;
  logic               any_pm;
  logic [2:0]         win_id;
  logic               grant;
  logic               w1c;
  logic               eoi_evt;
  logic               unused_wdata_hi;

  assign unused_wdata_hi = ^bus.wdata[31:N_IRQ];

  assign s1_d     = irq;
  assign s2_d     = s1_q;
  assign s3_d     = s2_q;
  assign edge_det = s2_q & ~s3_q;

  assign pm      = pend_q & mask_q;
  assign any_pm  = |pm;
  assign grant   = (state_q == ST_REQ) && bus.inta && any_pm;
  assign w1c     = bus.we && (bus.addr == 2'd0);
  assign eoi_evt = bus.eoi || (bus.we && (bus.addr == 2'd3));

  // Descending scan so the lowest set index is the last to assign.
  always_comb begin
    win_id = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pm[i]) win_id = i[2:0];
    end
  end

  // A new edge beats a same-cycle software clear so no event is lost.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (edge_det[i])                        pend_d[i] = 1'b1;
      else if (w1c && bus.wdata[i])           pend_d[i] = 1'b0;
      else if (grant && (win_id == i[2:0]))   pend_d[i] = 1'b0;
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (bus.we && (bus.addr == 2'd1)) mask_d = bus.wdata[N_IRQ-1:0];
  end

  // FSM: state register.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.ie && any_pm) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.inta && any_pm)      state_d = ST_SERVICE;
        else if (!bus.ie || !any_pm) state_d = ST_IDLE;
      end
      ST_SERVICE: if (eoi_evt) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs, registered so intr is a clean flop output.
  always_comb begin
    intr_d   = (state_d == ST_REQ);
    int_id_d = grant ? win_id : int_id_q;
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      intr_q   <= 1'b0;
      int_id_q <= 3'd0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      intr_q   <= intr_d;
      int_id_q <= int_id_d;
    end
  end

  assign bus.intr   = intr_q;
  assign bus.int_id = int_id_q;
  assign bus.cause  = {16'b0, pm, 3'b0, int_id_q, 2'b00};

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      2'd0:    bus.rdata = {24'b0, pend_q};
      2'd1:    bus.rdata = {24'b0, mask_q};
      2'd2:    bus.rdata = bus.cause;
      default: bus.rdata = 32'd0;
    endcase
  end

  assign dbg_state = state_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: hand-computed expectations for latency,
// priority, masking, set/clear collision, protocol abuse and async reset.
module tb_int_ctrl;
  logic       Clk;
  logic       Clrn;
  logic [7:0] irq;
  logic [1:0] dbg_state;

  int_ctrl_if bus ();

  int_ctrl dut (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .irq       (irq),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_SVC = 2'd2;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // Clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.we    = 1'b0;
    bus.wdata = 32'd0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic pulse_inta();
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
  endtask

  // One-cycle irq pulse, then wait until pend is set (edge k+2 from the rise).
  task automatic pulse_irq(input logic [7:0] lines);
    irq = lines;
    tick();
    irq = 8'h00;
    tick();
    tick();
  endtask

  logic [31:0] rd;

  initial begin
    Clrn = 1'b0; irq = 8'h00;
    bus.ie = 1'b0; bus.inta = 1'b0; bus.eoi = 1'b0;
    bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
    #2;
    check_eq("rst_intr",   {31'd0, bus.intr}, 32'd0);
    check_eq("rst_state",  {30'd0, dbg_state}, {30'd0, S_IDLE});
    check_eq("rst_int_id", {29'd0, bus.int_id}, 32'd0);
    check_eq("rst_cause",  bus.cause, 32'd0);
    reg_read(2'd0, rd); check_eq("rst_pend", rd, 32'd0);
    reg_read(2'd1, rd); check_eq("rst_mask", rd, 32'd0);
    #10 Clrn = 1'b1;
    tick();

    // Reset and single source
    reg_write(2'd1, 32'h01);
    reg_read(2'd1, rd); check_eq("mask_rd", rd, 32'h01);
    bus.ie = 1'b1;
    irq = 8'h01;
    tick();
    irq = 8'h00;
    tick();
    reg_read(2'd0, rd); check_eq("pend_k1", rd, 32'h00);
    tick();
    reg_read(2'd0, rd); check_eq("pend_k2", rd, 32'h01);
    check_eq("intr_k2", {31'd0, bus.intr}, 32'd0);
    tick();
    check_eq("intr_k3", {31'd0, bus.intr}, 32'd1);
    check_eq("state_req0", {30'd0, dbg_state}, {30'd0, S_REQ});
    pulse_inta();
    check_eq("ack0_intr",  {31'd0, bus.intr}, 32'd0);
    check_eq("ack0_id",    {29'd0, bus.int_id}, 32'd0);
    reg_read(2'd2, rd); check_eq("ack0_cause", rd, 32'h0);
    reg_read(2'd0, rd); check_eq("ack0_pend", rd, 32'h0);
    check_eq("state_svc0", {30'd0, dbg_state}, {30'd0, S_SVC});
    reg_write(2'd3, 32'h0);
    check_eq("eoi0_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // Priority
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd5);
    reg_write(2'd1, 32'hFF);
    pulse_irq(8'h24);
    tick();
    check_eq("prio_intr", {31'd0, bus.intr}, 32'd1);
    pulse_inta();
    check_eq("prio_id1", {29'd0, bus.int_id}, exp_q.pop_front());
    reg_read(2'd0, rd); check_eq("prio_pend", rd, 32'h20);
    reg_read(2'd2, rd); check_eq("prio_cause", rd, 32'h00002008);
    check_eq("prio_cause_port", bus.cause, 32'h00002008);
    reg_read(2'd3, rd); check_eq("eoi_rd0", rd, 32'h0);
    reg_write(2'd3, 32'h0);
    check_eq("prio_eoi_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check_eq("prio_eoi_intr",  {31'd0, bus.intr}, 32'd0);
    tick();
    check_eq("prio_reassert", {31'd0, bus.intr}, 32'd1);
    pulse_inta();
    check_eq("prio_id2", {29'd0, bus.int_id}, exp_q.pop_front());
    reg_read(2'd0, rd); check_eq("prio_pend2", rd, 32'h00);
    pulse_eoi();
    check_eq("eoi_pin_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // Masking and withdrawal
    reg_write(2'd1, 32'h00);
    pulse_irq(8'h08);
    reg_read(2'd0, rd); check_eq("mask_pend", rd, 32'h08);
    tick();
    check_eq("masked_intr", {31'd0, bus.intr}, 32'd0);
    reg_write(2'd1, 32'h08);
    tick();
    check_eq("unmask_intr", {31'd0, bus.intr}, 32'd1);
    reg_write(2'd0, 32'h08);
    reg_read(2'd0, rd); check_eq("w1c_pend", rd, 32'h00);
    tick();
    check_eq("withdraw_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check_eq("withdraw_intr",  {31'd0, bus.intr}, 32'd0);
    check_eq("withdraw_id",    {29'd0, bus.int_id}, 32'd5);

    // Set/clear collision on bit 4 (mask 0x08 keeps intr out of the way)
    irq = 8'h10;
    tick();
    irq = 8'h00;
    tick();
    reg_write(2'd0, 32'h10);
    reg_read(2'd0, rd); check_eq("collide_pend", rd, 32'h10);
    reg_write(2'd0, 32'h10);
    reg_read(2'd0, rd); check_eq("collide_clr", rd, 32'h00);

    // Level held high for 20 cycles gives one event
    irq = 8'h02;
    tick(); tick(); tick();
    reg_read(2'd0, rd); check_eq("level_pend", rd, 32'h02);
    reg_write(2'd0, 32'h02);
    for (int i = 0; i < 16; i++) tick();
    reg_read(2'd0, rd); check_eq("level_no_rearm", rd, 32'h00);
    irq = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    reg_read(2'd0, rd); check_eq("level_fall", rd, 32'h00);

    // Protocol abuse
    pulse_irq(8'h40);
    pulse_inta();
    check_eq("inta_idle_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    reg_read(2'd0, rd); check_eq("inta_idle_pend", rd, 32'h40);
    pulse_eoi();
    check_eq("eoi_idle_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    reg_read(2'd0, rd); check_eq("eoi_idle_pend", rd, 32'h40);
    reg_write(2'd1, 32'hC0);
    tick();
    check_eq("abuse_req", {30'd0, dbg_state}, {30'd0, S_REQ});
    pulse_inta();
    check_eq("abuse_id6", {29'd0, bus.int_id}, 32'd6);
    pulse_irq(8'h80);
    reg_read(2'd0, rd); check_eq("svc_pend", rd, 32'h80);
    pulse_inta();
    check_eq("inta_svc_state", {30'd0, dbg_state}, {30'd0, S_SVC});
    reg_read(2'd0, rd); check_eq("inta_svc_pend", rd, 32'h80);
    check_eq("inta_svc_id", {29'd0, bus.int_id}, 32'd6);
    pulse_eoi();
    tick();
    check_eq("ie_req", {30'd0, dbg_state}, {30'd0, S_REQ});
    bus.ie = 1'b0;
    tick();
    check_eq("ie_drop_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check_eq("ie_drop_intr",  {31'd0, bus.intr}, 32'd0);
    bus.ie = 1'b1;
    tick();
    pulse_inta();
    check_eq("svc7_state", {30'd0, dbg_state}, {30'd0, S_SVC});
    check_eq("svc7_id", {29'd0, bus.int_id}, 32'd7);

    // Async reset mid-SERVICE, between edges
    #2 Clrn = 1'b0;
    #1;
    check_eq("arst_intr",  {31'd0, bus.intr}, 32'd0);
    check_eq("arst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check_eq("arst_id",    {29'd0, bus.int_id}, 32'd0);
    reg_read(2'd0, rd); check_eq("arst_pend", rd, 32'h0);
    reg_read(2'd1, rd); check_eq("arst_mask", rd, 32'h0);
    check_eq("arst_cause", bus.cause, 32'h0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Vectored interrupt controller that sits directly upstream of the single-cycle CPU. It synchronises eight external interrupt lines and latches their rising edges into pending bits. It applies a software mask and raises a single `intr` request to the CPU. On the CPU's `inta` acknowledge it hands over the highest-priority source ID and a Cause-format word, then holds off further requests until end-of-interrupt (EOI). Software accesses the mask and pending registers through a small word-addressed register port on the data bus.

## Interface
- `N_IRQ`, 8, number of interrupt inputs; fixed at 8 in this revision, so IDs are 3 bits.
- `Clk` in 1: system clock, rising-edge.
- `Clrn` in 1: asynchronous active-low reset.
- `irq` in 8: external interrupt lines; asynchronous, active-high.
- `ie` in 1: global interrupt enable (CPU Status.IE).
- `inta` in 1: CPU acknowledge, one-cycle pulse.
- `eoi` in 1: end-of-interrupt pulse; equivalent to a write to address 3.
- `we` in 1: register write strobe.
- `addr` in 2: register select.
- `wdata` in 32: write data.
- `rdata` out 32: read data, combinational from `addr`.
- `intr` out 1: interrupt request to the CPU, registered.
- `int_id` out 3: ID of the source being serviced; valid in SERVICE.
- `cause` out 32: `{16'b0, pend&mask[7:0], 3'b0, int_id, 2'b00}`.

## Operation
- Register map:
  - addr 0 PEND: read returns `pend`. Write-1-to-clear.
  - addr 1 MASK: read/write `mask[7:0]`. 1 = enabled.
  - addr 2 CAUSE: read returns `cause`. Writes are ignored.
  - addr 3 EOI: any write acts as `eoi`. Reads return 0.
  - Bits [31:8] read as 0.
- Input path:
  - Per line, a 2-flop synchroniser (`s1`→`s2`) followed by a delay flop `s3`.
  - An edge is `s2 & ~s3`. An edge sets `pend[i]`.
- `pend[i]` next-value priority:
  1. An edge on line i sets the bit. This wins over any simultaneous clear.
  2. Otherwise, a W1C write with `wdata[i]=1` clears it.
  3. Otherwise, an `inta` that grants source i clears it.
- Priority: the lowest index among `pend&mask` wins.
- FSM states:
  - IDLE:
    - `intr=0`.
    - Go to REQ when `ie & |(pend&mask)`.
  - REQ:
    - `intr=1`.
    - If `inta`: latch the winning ID into `int_id`, clear its pend bit, go to SERVICE.
    - Else if `~ie` or `(pend&mask)==0` (masked or cleared by software): return to IDLE without servicing.
  - SERVICE:
    - `intr=0`. No nesting.
    - On `eoi` or a write to addr 3: return to IDLE.
    - `inta` is ignored in this state.
- `inta` in IDLE is ignored. No state change, no pend clear.
- `eoi` outside SERVICE is ignored.
- Reset mid-operation (`Clrn` low in any state) forces IDLE immediately and clears all flops.

## Timing
- Reset values:
  - `pend=0`, `mask=0` (all sources disabled).
  - `s1`, `s2`, `s3` = 0.
  - `int_id=0`, state IDLE, `intr=0`.
  - `cause=0`, `rdata` reflects zeroed registers.
- Latency:
  - `irq[i]` rising before edge k makes `pend[i]=1` after edge k+2.
  - `intr` goes high after edge k+3, provided `mask[i]` and `ie` are set and the FSM is in IDLE.
- A level held high produces exactly one pending event. It must go low for at least 1 cycle (as seen at `s2`) to re-arm.
- `inta` sampled at edge n: after edge n, `intr=0`, `int_id` is valid, and the granted pend bit is cleared.
- EOI at edge m: state is IDLE after m. If pending sources remain, `intr` re-asserts after m+1.
- Register writes take effect at the clock edge. The mask gates `intr` evaluation in the next cycle.

## Test plan
- Reset and single source:
  - Stimulus: release `Clrn`, write MASK=0x01, set `ie=1`, pulse `irq[0]`.
  - Required: `pend=0x01` 3 edges later; `intr=1` 1 edge after that.
  - Then `inta`: `int_id=0`, `cause=0x00000000`, `pend=0`, `intr=0`.
  - Then EOI write: FSM returns to IDLE.
- Priority:
  - Stimulus: MASK=0xFF, `irq[5]` and `irq[2]` rise together, then `inta`.
  - Required: `int_id=2`, `pend=0x20`, `cause=0x00002008`.
  - After EOI: `intr` re-asserts; the next `inta` gives `int_id=5`.
- Masking and withdrawal:
  - Stimulus: MASK=0x00, pulse `irq[3]`.
  - Required: `pend=0x08`, `intr` stays 0.
  - Write MASK=0x08: `intr=1`.
  - Write PEND=0x08 while in REQ: state returns to IDLE, `intr=0`, no `int_id` update.
- Set/clear collision:
  - Stimulus: a W1C of bit 4 lands on the same edge as a new edge on `irq[4]`.
  - Required: `pend[4]=1`.
  - Stimulus: a level held high on `irq[1]` for 20 cycles.
  - Required: exactly one pend event.
- Protocol abuse:
  - Stimulus: `inta` in IDLE; `eoi` in IDLE; `inta` in SERVICE.
  - Required: no state or pend change in any of the three cases.
  - Stimulus: drop `ie` during REQ.
  - Required: state IDLE, `intr=0`.
- Async reset mid-SERVICE:
  - Stimulus: assert `Clrn=0` between clock edges.
  - Required: `intr`, `pend`, `mask`, `int_id` = 0 immediately; FSM in IDLE.
